// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point FFT datapath and its frame loader.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_W     = 16;

  typedef enum logic {
    LOADER_FILL = 1'b0,
    LOADER_HOLD = 1'b1
  } loader_state_e;

  // Mirrors the index bits; the core uses the same routine for its output ordering.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = k[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples: single write port, whole frame read out as packed buses.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [LOG2N-1:0] addr_i,
  input  logic [W-1:0]     re_i,
  input  logic [W-1:0]     im_i,
  output logic [N*W-1:0]   re_o,
  output logic [N*W-1:0]   im_o
);

  logic [W-1:0] re_q [N];
  logic [W-1:0] im_q [N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (we_i) begin
      re_q[addr_i] <= re_i;
      im_q[addr_i] <= im_i;
    end
  end

  always_comb begin
    re_o = '0;
    im_o = '0;
    for (int s = 0; s < N; s++) begin
      re_o[s*W +: W] = re_q[s];
      im_o[s*W +: W] = im_q[s];
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles a serial sample stream into ping-pong frames for the FFT core and
// toggles new_input_flag each time a completed frame is presented.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int W           = FFT_W,
  parameter int N           = FFT_N,
  parameter int LOG2N       = FFT_LOG2N,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_real,
  input  logic [W-1:0]   in_imag,
  input  logic           flush,
  input  logic           frame_ack,
  output logic [N*W-1:0] out_real,
  output logic [N*W-1:0] out_imag,
  output logic           new_input_flag,
  output logic           frame_valid
);

  loader_state_e    state_q;
  logic [LOG2N-1:0] wr_idx_q;
  logic             wr_bank_q;
  logic             pres_bank_q;
  logic             frame_valid_q;
  logic             flag_q;

  logic             accept;
  logic             last;
  logic             swap;
  logic [LOG2N-1:0] wr_slot;
  logic [N*W-1:0]   bank0_re, bank0_im, bank1_re, bank1_im;

  // A flush in the same cycle as a sample drops the sample, so it never reaches a bank.
  assign in_ready = (state_q == LOADER_FILL);
  assign accept   = in_valid && in_ready && !flush;
  assign last     = (wr_idx_q == LOG2N'(N-1));
  assign swap     = !flush &&
                    ((accept && last && (!frame_valid_q || frame_ack)) ||
                     (state_q == LOADER_HOLD && frame_ack));
  assign wr_slot  = BIT_REVERSE ? bitrev(wr_idx_q) : wr_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOADER_FILL;
      wr_idx_q      <= '0;
      wr_bank_q     <= 1'b0;
      pres_bank_q   <= 1'b1;
      frame_valid_q <= 1'b0;
      flag_q        <= 1'b0;
    end else begin
      if (flush) begin
        wr_idx_q <= '0;
        state_q  <= LOADER_FILL;
      end else if (swap) begin
        wr_idx_q    <= '0;
        state_q     <= LOADER_FILL;
        wr_bank_q   <= ~wr_bank_q;
        pres_bank_q <= wr_bank_q;
      end else if (accept) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        if (last) state_q <= LOADER_HOLD;
      end

      if (swap) begin
        frame_valid_q <= 1'b1;
        flag_q        <= ~flag_q;
      end else if (frame_ack) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  fft_frame_bank #(.W(W), .N(N), .LOG2N(LOG2N)) u_bank0 (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (accept && !wr_bank_q),
    .addr_i (wr_slot),
    .re_i   (in_real),
    .im_i   (in_imag),
    .re_o   (bank0_re),
    .im_o   (bank0_im)
  );

  fft_frame_bank #(.W(W), .N(N), .LOG2N(LOG2N)) u_bank1 (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (accept && wr_bank_q),
    .addr_i (wr_slot),
    .re_i   (in_real),
    .im_i   (in_imag),
    .re_o   (bank1_re),
    .im_o   (bank1_im)
  );

  assign out_real       = pres_bank_q ? bank1_re : bank0_re;
  assign out_imag       = pres_bank_q ? bank1_im : bank0_im;
  assign frame_valid    = frame_valid_q;
  assign new_input_flag = flag_q;

endmodule
